// File: rtl/instr_fetch_pkg.sv
// Shared defaults for the instruction fetch unit and its return buffer.
package instr_fetch_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_ADDR_WIDTH   = 12;
   localparam int DEF_RESET_PC     = 0;
   localparam int FETCH_FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W       = $clog2(FETCH_FIFO_DEPTH + 1);

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry buffer for returned ROM words tagged with their fetch address.
// Head entry is a plain register so the decode-facing outputs carry no combinational path.
module fetch_skid_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [ADDR_WIDTH-1:0] head_pc,
   output logic [FIFO_CNT_W-1:0] count
);

   localparam logic [FIFO_CNT_W-1:0] FULL = FIFO_CNT_W'(FETCH_FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] tail_data;
   logic [ADDR_WIDTH-1:0] tail_pc;

   assign head_valid = (count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         head_data <= '0;
         head_pc   <= '0;
         tail_data <= '0;
         tail_pc   <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == '0) begin
                  head_data <= push_data;
                  head_pc   <= push_pc;
               end else begin
                  tail_data <= push_data;
                  tail_pc   <= push_pc;
               end
               count <= count + 1'b1;
            end
            2'b01: begin
               head_data <= tail_data;
               head_pc   <= tail_pc;
               count     <= count - 1'b1;
            end
            2'b11: begin
               // Occupancy is unchanged; only the entry order moves.
               if (count == FULL) begin
                  head_data <= tail_data;
                  head_pc   <= tail_pc;
                  tail_data <= push_data;
                  tail_pc   <= push_pc;
               end else begin
                  head_data <= push_data;
                  head_pc   <= push_pc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetch against a 1-cycle registered ROM with redirect and decode backpressure.
// Issues only when the return buffer is guaranteed room, so no returned word is ever dropped.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RESET_PC   = DEF_RESET_PC
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic                  rom_rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(RESET_PC);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic                  inflight;
   logic [FIFO_CNT_W-1:0] count;
   logic [2:0]            load;
   logic                  pop;
   logic                  push;
   logic                  issue;

   assign rom_rst_n = ~reset;
   assign pop       = instr_valid & instr_ready;
   assign push      = inflight & ~redirect_valid;

   // A word leaving this cycle frees its slot, which keeps throughput at one per cycle.
   assign load  = 3'(count) + 3'(inflight) - 3'(pop);
   assign issue = redirect_valid | (load < 3'd2);

   always_comb begin
      if (reset)               rom_addr = RST_ADDR;
      else if (redirect_valid) rom_addr = redirect_pc;
      else if (issue)          rom_addr = pc;
      else                     rom_addr = last_addr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RST_ADDR;
         last_addr   <= RST_ADDR;
         inflight    <= 1'b0;
         inflight_pc <= RST_ADDR;
      end else begin
         last_addr <= rom_addr;
         if (redirect_valid) begin
            pc          <= redirect_pc + 1'b1;
            inflight    <= 1'b1;
            inflight_pc <= redirect_pc;
         end else if (issue) begin
            pc          <= pc + 1'b1;
            inflight    <= 1'b1;
            inflight_pc <= pc;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   fetch_skid_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (rom_q),
      .push_pc    (inflight_pc),
      .pop        (pop),
      .flush      (redirect_valid),
      .head_valid (instr_valid),
      .head_data  (instr),
      .head_pc    (instr_pc),
      .count      (count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench: two fetch units (RESET_PC 0 and 0xFFE) each fed by a registered ROM model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_ready;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   int          checks = 0;
   int          errors = 0;

   logic [11:0] rom_addr0, instr_pc0;
   logic [31:0] rom_q0, instr0;
   logic        rom_rst_n0, instr_valid0;

   logic [11:0] rom_addr1, instr_pc1;
   logic [31:0] rom_q1, instr1;
   logic        rom_rst_n1, instr_valid1;
   logic        ready1 = 1'b1;
   logic        redirect_valid1 = 1'b0;
   logic [11:0] redirect_pc1 = 12'h000;

   always #5 clk = ~clk;

   always @(posedge clk) rom_q0 <= rom_rst_n0 ? (32'h1000_0000 + {20'd0, rom_addr0}) : 32'd0;
   always @(posedge clk) rom_q1 <= rom_rst_n1 ? (32'h1000_0000 + {20'd0, rom_addr1}) : 32'd0;

   instr_fetch dut0 (
      .clk(clk), .reset(reset), .rom_addr(rom_addr0), .rom_q(rom_q0), .rom_rst_n(rom_rst_n0),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid0), .instr_ready(instr_ready), .instr(instr0), .instr_pc(instr_pc0)
   );

   instr_fetch #(.RESET_PC(12'hFFE)) dut1 (
      .clk(clk), .reset(reset), .rom_addr(rom_addr1), .rom_q(rom_q1), .rom_rst_n(rom_rst_n1),
      .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
      .instr_valid(instr_valid1), .instr_ready(ready1), .instr(instr1), .instr_pc(instr_pc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string tag, input logic [11:0] pc_exp, input logic [31:0] dat_exp);
      chk({tag, "_valid"}, 32'(instr_valid0), 32'd1);
      chk({tag, "_pc"}, 32'(instr_pc0), 32'(pc_exp));
      chk({tag, "_instr"}, instr0, dat_exp);
   endtask

   initial begin
      reset = 1'b1;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 12'h000;
      #2;
      chk("rst_valid", 32'(instr_valid0), 32'd0);
      chk("rst_instr", instr0, 32'd0);
      chk("rst_pc", 32'(instr_pc0), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr0), 32'h000);
      chk("rst_rom_addr_ffe", 32'(rom_addr1), 32'hFFE);
      chk("rst_rom_rst_n", 32'(rom_rst_n0), 32'd0);
      step();
      step();
      reset = 1'b0;

      // Release: valid appears on the second edge, then one word per cycle.
      step();
      chk("rel_e1_valid", 32'(instr_valid0), 32'd0);
      chk("rel_e1_rom_addr", 32'(rom_addr0), 32'h001);
      chk("rel_e1_valid_ffe", 32'(instr_valid1), 32'd0);
      step();
      chk_word("str0", 12'h000, 32'h1000_0000);
      chk("wrap0_pc", 32'(instr_pc1), 32'hFFE);
      chk("wrap0_instr", instr1, 32'h1000_0FFE);
      step();
      chk_word("str1", 12'h001, 32'h1000_0001);
      chk("wrap1_pc", 32'(instr_pc1), 32'hFFF);
      step();
      chk_word("str2", 12'h002, 32'h1000_0002);
      chk("wrap2_pc", 32'(instr_pc1), 32'h000);
      chk("wrap2_instr", instr1, 32'h1000_0000);
      step();
      chk_word("str3", 12'h003, 32'h1000_0003);
      chk("wrap3_pc", 32'(instr_pc1), 32'h001);

      // Backpressure: word 3 holds, word 4 buffered, no further issue.
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_word("stall", 12'h003, 32'h1000_0003);
         chk("stall_rom_addr", 32'(rom_addr0), 32'h004);
      end
      instr_ready = 1'b1;
      step();
      chk_word("resume4", 12'h004, 32'h1000_0004);
      step();
      chk_word("resume5", 12'h005, 32'h1000_0005);
      step();
      chk_word("resume6", 12'h006, 32'h1000_0006);
      step();
      chk_word("pre7", 12'h007, 32'h1000_0007);

      // Buffer 7 and 8, then redirect to 0x800.
      instr_ready = 1'b0;
      step();
      chk_word("hold7", 12'h007, 32'h1000_0007);
      redirect_valid = 1'b1;
      redirect_pc = 12'h800;
      #1;
      chk("redir_rom_addr", 32'(rom_addr0), 32'h800);
      step();
      redirect_valid = 1'b0;
      chk("redir_flush_valid", 32'(instr_valid0), 32'd0);
      instr_ready = 1'b1;
      step();
      chk_word("redir800", 12'h800, 32'h1000_0800);
      step();
      chk_word("redir801", 12'h801, 32'h1000_0801);

      // Back-to-back redirects: only 0x200 survives.
      redirect_valid = 1'b1;
      redirect_pc = 12'h100;
      step();
      chk("b2b_e1_valid", 32'(instr_valid0), 32'd0);
      redirect_pc = 12'h200;
      #1;
      chk("b2b_rom_addr", 32'(rom_addr0), 32'h200);
      step();
      redirect_valid = 1'b0;
      redirect_pc = 12'h555;
      chk("b2b_e2_valid", 32'(instr_valid0), 32'd0);
      step();
      chk_word("b2b200", 12'h200, 32'h1000_0200);
      step();
      chk_word("b2b201", 12'h201, 32'h1000_0201);
      step();
      chk_word("ignore_rpc", 12'h202, 32'h1000_0202);

      // Toggle ready, then reset asynchronously mid-cycle.
      instr_ready = 1'b0;
      step();
      chk_word("tog_hold", 12'h202, 32'h1000_0202);
      instr_ready = 1'b1;
      step();
      chk_word("tog_203", 12'h203, 32'h1000_0203);
      instr_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(instr_valid0), 32'd0);
      chk("mid_rst_instr", instr0, 32'd0);
      chk("mid_rst_pc", 32'(instr_pc0), 32'd0);
      chk("mid_rst_rom_addr", 32'(rom_addr0), 32'h000);
      step();
      step();
      reset = 1'b0;
      instr_ready = 1'b1;
      step();
      chk("restart_e1_valid", 32'(instr_valid0), 32'd0);
      step();
      chk_word("restart0", 12'h000, 32'h1000_0000);
      step();
      chk_word("restart1", 12'h001, 32'h1000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
